// File: rtl/fetch_unit.sv
// fetch_unit: picoMIPS fetch stage holding the PC, slicing ROM words and debouncing SW8.
module fetch_unit #(
  parameter int O_SIZE     = 6,
  parameter int R_SIZE     = 3,
  parameter int IMM_SIZE   = 8,
  parameter int PC_SIZE    = 6,
  parameter int PROG_LEN   = 64,
  parameter int DEB_CYCLES = 4
) (
  input  logic                                clk,
  input  logic                                nReset,
  input  logic                                pcInc,
  input  logic                                demoSwitchRaw,
  input  logic [O_SIZE+2*R_SIZE+IMM_SIZE-1:0] romData,
  output logic [PC_SIZE-1:0]                  romAddr,
  output logic [O_SIZE-1:0]                   opCode,
  output logic [R_SIZE-1:0]                   regD,
  output logic [R_SIZE-1:0]                   regS,
  output logic [IMM_SIZE-1:0]                 immediate,
  output logic                                instrValid,
  output logic [PC_SIZE-1:0]                  pc,
  output logic                                demoSwitch,
  output logic [15:0]                         retired
);
  localparam int W  = O_SIZE + 2*R_SIZE + IMM_SIZE;
  localparam int CW = $clog2(DEB_CYCLES + 1);
  typedef enum logic {FILL, RUN} state_t;
  state_t state;
  logic [PC_SIZE-1:0] nextPc;
  logic adv, sync1, swS;
  logic [CW-1:0] debCnt;
  assign nextPc    = (pc == PC_SIZE'(PROG_LEN - 1)) ? '0 : pc + 1'b1;
  assign adv       = (state == RUN) && pcInc;
  // Presenting nextPc early lets the registered ROM deliver one word per cycle.
  assign romAddr   = adv ? nextPc : pc;
  assign opCode    = romData[W-1 -: O_SIZE];
  assign regD      = romData[W-O_SIZE-1 -: R_SIZE];
  assign regS      = romData[W-O_SIZE-R_SIZE-1 -: R_SIZE];
  assign immediate = romData[IMM_SIZE-1:0];
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      state      <= FILL;
      pc         <= '0;
      instrValid <= 1'b0;
      retired    <= '0;
    end else begin
      state      <= RUN;
      instrValid <= 1'b1;
      if (adv) pc <= nextPc;
      retired    <= retired + 16'(adv && retired != 16'hFFFF);
    end
  // Switch only after DEB_CYCLES consecutive synchronised disagreements.
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      sync1      <= 1'b0;
      swS        <= 1'b0;
      debCnt     <= '0;
      demoSwitch <= 1'b0;
    end else begin
      sync1 <= demoSwitchRaw;
      swS   <= sync1;
      if (swS == demoSwitch) debCnt <= '0;
      else if (debCnt == CW'(DEB_CYCLES - 1)) begin
        demoSwitch <= swS;
        debCnt     <= '0;
      end else debCnt <= debCnt + 1'b1;
    end
endmodule
